// File: rtl/melody_sequencer.sv
// Pattern-RAM driven square-wave melody player: one note half-period per step,
// fixed step length, optional staccato gating and looping.
module melody_sequencer #(
    parameter int NUM_STEPS  = 24,
    parameter int HP_W       = 20,
    parameter int TICK_W     = 24,
    parameter int STEP_TICKS = 10714284,
    parameter int GATE_TICKS = 1785714,
    localparam int AW        = $clog2(NUM_STEPS)
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_wr_en,
    input  logic [AW-1:0]   i_wr_addr,
    input  logic [HP_W-1:0] i_wr_data,
    input  logic            i_start,
    input  logic            i_stop,
    input  logic            i_loop_en,
    input  logic            i_legato,
    input  logic [AW-1:0]   i_last_step,
    output logic            o_speaker,
    output logic [AW-1:0]   o_step,
    output logic            o_busy,
    output logic            o_done
);

    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(STEP_TICKS - 1);
    localparam logic [TICK_W:0]   GATE_LIM   = (TICK_W + 1)'(GATE_TICKS);
    localparam logic [AW:0]       STEP_MAX   = (AW + 1)'(NUM_STEPS - 1);
    localparam logic [AW-1:0]     STEP_MAX_A = AW'(NUM_STEPS - 1);

    typedef enum logic {S_IDLE, S_PLAY} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [HP_W-1:0] r_ram [NUM_STEPS];
    logic [AW-1:0]   r_step;
    logic [AW-1:0]   r_last;
    logic [TICK_W-1:0] r_tick;
    logic [HP_W-1:0] r_hp;
    logic [HP_W-1:0] r_tone_cnt;
    logic            r_tone;
    logic            r_loop;
    logic            r_legato;
    logic            r_done;

    logic            w_go;
    logic            w_abort;
    logic            w_finish;
    logic            w_step_end;
    logic            w_at_last;
    logic [AW-1:0]   w_next_step;
    logic [AW-1:0]   w_last_clamped;
    logic            w_wr_ok;
    logic            w_gate;

    assign w_step_end     = (r_tick == TICK_LAST);
    assign w_at_last      = (r_step == r_last);
    assign w_next_step    = w_at_last ? '0 : r_step + AW'(1);
    assign w_last_clamped = ({1'b0, i_last_step} > STEP_MAX) ? STEP_MAX_A : i_last_step;
    assign w_wr_ok        = ({1'b0, i_wr_addr} <= STEP_MAX);
    assign w_gate         = (r_state == S_PLAY) && (r_hp != '0) &&
                            (r_legato || ({1'b0, r_tick} < GATE_LIM));

    always_comb begin
        w_state_nxt = r_state;
        w_go        = 1'b0;
        w_abort     = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start && !i_stop) begin
                    w_state_nxt = S_PLAY;
                    w_go        = 1'b1;
                end
            end
            S_PLAY: begin
                // stop beats a coincident end-of-sequence, so no done pulse then
                if (i_stop) begin
                    w_state_nxt = S_IDLE;
                    w_abort     = 1'b1;
                end else if (w_step_end && w_at_last && !r_loop) begin
                    w_state_nxt = S_IDLE;
                    w_finish    = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_step     <= '0;
            r_last     <= '0;
            r_tick     <= '0;
            r_hp       <= '0;
            r_tone_cnt <= '0;
            r_tone     <= 1'b0;
            r_loop     <= 1'b0;
            r_legato   <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_finish;
            if (w_go) begin
                r_step     <= '0;
                r_tick     <= '0;
                r_tone_cnt <= '0;
                r_tone     <= 1'b0;
                r_hp       <= r_ram[0];
                r_loop     <= i_loop_en;
                r_legato   <= i_legato;
                r_last     <= w_last_clamped;
            end else if (r_state == S_PLAY) begin
                if (w_abort || w_finish) begin
                    r_step     <= '0;
                    r_tick     <= '0;
                    r_tone_cnt <= '0;
                    r_tone     <= 1'b0;
                    r_hp       <= '0;
                end else if (w_step_end) begin
                    // hp is sampled only here, so live writes wait for the next entry
                    r_step     <= w_next_step;
                    r_tick     <= '0;
                    r_tone_cnt <= '0;
                    r_tone     <= 1'b0;
                    r_hp       <= r_ram[w_next_step];
                end else begin
                    r_tick <= r_tick + TICK_W'(1);
                    if (!w_gate) begin
                        r_tone_cnt <= '0;
                        r_tone     <= 1'b0;
                    end else if (r_tone_cnt == r_hp - HP_W'(1)) begin
                        r_tone_cnt <= '0;
                        r_tone     <= ~r_tone;
                    end else begin
                        r_tone_cnt <= r_tone_cnt + HP_W'(1);
                    end
                end
            end
        end
    end

    // Pattern RAM is deliberately outside the reset domain.
    always_ff @(posedge i_clk) begin
        if (i_wr_en && w_wr_ok) begin
            r_ram[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_speaker = r_tone & w_gate;
    assign o_step    = r_step;
    assign o_busy    = (r_state == S_PLAY);
    assign o_done    = r_done;

endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer: directed scenarios with literal expectations plus
// random traffic, all checked every cycle against a step/tick-level model.
module tb_melody_sequencer;

    localparam int N  = 4;
    localparam int HW = 8;
    localparam int TW = 8;
    localparam int ST = 20;
    localparam int GT = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wr_en = 1'b0;
    logic [1:0]    wr_addr = '0;
    logic [HW-1:0] wr_data = '0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          loop_en = 1'b0;
    logic          legato = 1'b0;
    logic [1:0]    last_step = '0;
    logic          speaker;
    logic [1:0]    step;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    melody_sequencer #(
        .NUM_STEPS(N), .HP_W(HW), .TICK_W(TW), .STEP_TICKS(ST), .GATE_TICKS(GT)
    ) dut (
        .i_clk(clk), .i_reset(reset), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
        .i_wr_data(wr_data), .i_start(start), .i_stop(stop), .i_loop_en(loop_en),
        .i_legato(legato), .i_last_step(last_step), .o_speaker(speaker),
        .o_step(step), .o_busy(busy), .o_done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // Reference model: tracks only play state, step and tick; tone is derived in closed form.
    bit m_play = 0;
    int m_step = 0;
    int m_tick = 0;
    int m_hp = 0;
    bit m_loop = 0;
    bit m_leg = 0;
    int m_last = 0;
    bit m_done = 0;
    int m_ram [N] = '{default: 0};

    always @(posedge clk) begin
        m_done = 0;
        if (reset) begin
            m_play = 0; m_step = 0; m_tick = 0;
        end else if (!m_play) begin
            if (start && !stop) begin
                m_play = 1; m_step = 0; m_tick = 0; m_hp = m_ram[0];
                m_loop = loop_en; m_leg = legato;
                m_last = (int'(last_step) >= N) ? N - 1 : int'(last_step);
            end
        end else if (stop) begin
            m_play = 0; m_step = 0; m_tick = 0;
        end else if (m_tick == ST - 1) begin
            m_tick = 0;
            if (m_step == m_last) begin
                if (m_loop) begin
                    m_step = 0; m_hp = m_ram[0];
                end else begin
                    m_play = 0; m_step = 0; m_done = 1;
                end
            end else begin
                m_step = m_step + 1; m_hp = m_ram[m_step];
            end
        end else begin
            m_tick = m_tick + 1;
        end
        if (wr_en && int'(wr_addr) < N) m_ram[wr_addr] = int'(wr_data);
    end

    initial begin
        bit exp_spk;
        @(posedge clk);
        forever begin
            @(negedge clk);
            exp_spk = 0;
            if (m_play && m_hp != 0 && (m_leg || m_tick < GT))
                exp_spk = ((m_tick / m_hp) % 2) == 1;
            check("model_busy", busy, m_play);
            check("model_step", step, m_step);
            check("model_done", done, m_done);
            check("model_speaker", speaker, exp_spk);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [HW-1:0] d);
        wr_en = 1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 0;
    endtask

    // Returns at the negedge of tick 0 of step 0.
    task automatic play(input logic lp, input logic lg, input logic [1:0] ls);
        start = 1; loop_en = lp; legato = lg; last_step = ls;
        @(negedge clk);
        start = 0;
    endtask

    initial begin
        cyc(3);
        reset = 0;
        cyc(1);
        check("rst_busy", busy, 0);
        check("rst_step", step, 0);
        check("rst_done", done, 0);
        check("rst_speaker", speaker, 0);

        wr(0, 3); wr(1, 0); wr(2, 5); wr(3, 2);

        // staccato, no loop
        play(0, 0, 3);
        cyc(3);  check("stac_t3_high", speaker, 1);
        cyc(3);  check("stac_t6_low", speaker, 0);
        cyc(14); check("stac_step1", step, 1);
        check("stac_rest", speaker, 0);
        cyc(60); check("stac_done", done, 1);
        check("stac_idle", busy, 0);
        cyc(1);  check("stac_done_once", done, 0);

        // legato
        play(0, 1, 3);
        cyc(44); check("leg_t44_low", speaker, 0);
        check("leg_step2", step, 2);
        cyc(1);  check("leg_t45_high", speaker, 1);
        cyc(15); check("leg_step3", step, 3);
        check("leg_s3_restart_low", speaker, 0);
        cyc(2);  check("leg_s3_t2_high", speaker, 1);
        cyc(18); check("leg_done", done, 1);
        cyc(2);

        // loop over steps 0..1, then stop at cycle 50
        play(1, 0, 1);
        cyc(20); check("loop_step1", step, 1);
        cyc(20); check("loop_wrap0", step, 0);
        check("loop_busy", busy, 1);
        cyc(10); stop = 1;
        cyc(1);  stop = 0;
        check("stop_busy", busy, 0);
        check("stop_speaker", speaker, 0);
        check("stop_step", step, 0);

        // collisions
        start = 1; stop = 1;
        cyc(1); start = 0; stop = 0;
        cyc(1); check("startstop_idle", busy, 0);
        play(0, 0, 3);
        cyc(25); start = 1;
        cyc(1);  start = 0;
        check("start_in_play_step", step, 1);
        stop = 1; cyc(1); stop = 0;

        // reset at tick 10 of step 2, then replay
        play(0, 0, 3);
        cyc(50); reset = 1;
        cyc(1);  reset = 0;
        check("midrst_busy", busy, 0);
        check("midrst_step", step, 0);
        check("midrst_done", done, 0);
        check("midrst_speaker", speaker, 0);
        cyc(2);
        play(0, 0, 3);
        cyc(3);  check("replay_t3_high", speaker, 1);
        cyc(77); check("replay_done", done, 1);
        cyc(2);

        // live write to step 0 while it plays; last_step 7 truncates/clamps to 3
        play(1, 1, 2'(7));
        cyc(5);  wr(0, 7);
        cyc(1);  check("live_old_hp_t7", speaker, 0);
        cyc(53); check("clamp_step3", step, 3);
        cyc(20); check("live_wrap_step0", step, 0);
        check("live_wrap_busy", busy, 1);
        cyc(7);  check("live_new_hp_t7", speaker, 1);
        stop = 1; cyc(1); stop = 0;

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            reset     = ($urandom_range(0, 299) == 0);
            start     = ($urandom_range(0, 24) == 0);
            stop      = ($urandom_range(0, 119) == 0);
            wr_en     = ($urandom_range(0, 3) == 0);
            wr_addr   = 2'($urandom_range(0, 3));
            wr_data   = HW'($urandom_range(0, 6));
            loop_en   = 1'($urandom_range(0, 1));
            legato    = 1'($urandom_range(0, 1));
            last_step = 2'($urandom_range(0, 3));
            cyc(1);
        end
        reset = 0; start = 0; stop = 0; wr_en = 0;
        cyc(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
